sp_query_arbiter: RTL

SP_QUERY_ARBITER -- requirements
Module: sp_query_arbiter

---
 rtl/sp_query_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sp_query_arbiter.sv
// Round-robin arbiter that funnels requester coordinates into a fixed-latency
// shortest-path engine and routes each result back to its requester.

module sp_req_slot #(
    parameter int ROWS = 30,
    parameter int COLS = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       sp_ready,
    input  logic       grant,
    input  logic       ack,
    input  logic [9:0] r,
    input  logic [9:0] c,
    output logic       elig,
    output logic       oor
);
    logic pending;

    // A grant and an ack never hit the same slot in one cycle, so order is moot.
    always_ff @(posedge clk) begin
        if (rst)        pending <= 1'b0;
        else if (grant) pending <= 1'b1;
        else if (ack)   pending <= 1'b0;
    end

    assign elig = req & ~pending & sp_ready;
    assign oor  = (r >= 10'(ROWS)) || (c >= 10'(COLS));
endmodule

module sp_query_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT   = 2,
    parameter int ROWS  = 30,
    parameter int COLS  = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [10*N_REQ-1:0] req_r,
    input  logic [10*N_REQ-1:0] req_c,
    input  logic               sp_ready,
    output logic [9:0]         query_r,
    output logic [9:0]         query_c,
    input  logic [2:0]         sp_dir,
    input  logic [9:0]         sp_dist,
    output logic [N_REQ-1:0]   ack,
    output logic [2:0]         rsp_dir,
    output logic [9:0]         rsp_dist
);
    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0][9:0] r_arr, c_arr;
    logic [N_REQ-1:0]      elig, oor, gnt_oh;
    logic [IDXW-1:0]       ptr, gnt_idx;
    logic [IDXW:0]         cand;
    logic                  gnt_vld;

    logic [LAT:0]           vld_pipe;
    logic [LAT:0]           oor_pipe;
    logic [LAT:0][IDXW-1:0] idx_pipe;

    assign r_arr = req_r;
    assign c_arr = req_c;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        sp_req_slot #(.ROWS(ROWS), .COLS(COLS)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .req      (req[i]),
            .sp_ready (sp_ready),
            .grant    (gnt_oh[i]),
            .ack      (ack[i]),
            .r        (r_arr[i]),
            .c        (c_arr[i]),
            .elig     (elig[i]),
            .oor      (oor[i])
        );
    end

    // First eligible requester at or after ptr, wrapping around.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDXW+1)'(k);
            if (cand >= (IDXW+1)'(N_REQ)) cand = cand - (IDXW+1)'(N_REQ);
            if (!gnt_vld && elig[cand[IDXW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IDXW-1:0];
            end
        end
    end

    assign gnt_oh = gnt_vld ? (N_REQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            query_r <= '0;
            query_c <= '0;
        end else if (gnt_vld) begin
            ptr <= (gnt_idx == IDXW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
            // Out-of-range coordinates never reach the engine; the response is synthesized.
            if (!oor[gnt_idx]) begin
                query_r <= r_arr[gnt_idx];
                query_c <= c_arr[gnt_idx];
            end
        end
    end

    // Tag stage LAT lines up with the engine result for the same query.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            oor_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LAT-1:0], gnt_vld};
            oor_pipe <= {oor_pipe[LAT-1:0], oor[gnt_idx]};
            idx_pipe <= {idx_pipe[LAT-1:0], gnt_idx};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack      <= '0;
            rsp_dir  <= '0;
            rsp_dist <= '0;
        end else if (vld_pipe[LAT]) begin
            ack      <= N_REQ'(1) << idx_pipe[LAT];
            rsp_dir  <= oor_pipe[LAT] ? 3'd0 : sp_dir;
            rsp_dist <= oor_pipe[LAT] ? 10'h3FF : sp_dist;
        end else begin
            ack <= '0;
        end
    end
endmodule
